regfile_sb: RTL and testbench
=============================

# regfile_sb

Parametrised general-purpose register file with two write ports, optional same-cycle write-to-read bypass, a hardwired zero register, and a per-register busy scoreboard for multi-cycle results. It sits between decode and execute in the datapath. It replaces the fixed 16×16 file with its dedicated R15 port: the secondary write port is now addressable, and a configurable special register is exported continuously.

## Interface
- WIDTH, 16, data width in bits
- ADDR_W, 4, address width; DEPTH = 2**ADDR_W registers
- SPEC_IDX, 15, index of the register driven on spec_data
- BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = reads return stored value only
- ZERO_REG, 1, 1 = register 0 reads zero, ignores writes, is never busy
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- rd_addr_a, rd_addr_b  in  ADDR_W  read addresses
- rd_data_a, rd_data_b  out  WIDTH  combinational read data
- rd_busy_a, rd_busy_b  out  1  combinational busy flag of the addressed register
- spec_data  out  WIDTH  combinational contents of register SPEC_IDX (bypass rules apply)
- wr0_en, wr0_addr, wr0_data  in  1/ADDR_W/WIDTH  primary write port (ALU writeback)
- wr1_en, wr1_addr, wr1_data  in  1/ADDR_W/WIDTH  secondary write port (multi-cycle unit / former R15 path)
- sb_set_en, sb_set_addr  in  1/ADDR_W  mark a register busy (multi-cycle op issued)
- sb_count  out  ADDR_W+1  registered number of busy registers
- wr_conflict  out  1  registered one-cycle pulse: both ports wrote the same non-zero address

## Operation
- Storage: DEPTH × WIDTH registers plus DEPTH busy bits.
- Writes commit at the rising edge when enabled.
- Both ports enabled with the same address: wr1 wins; wr0 is dropped; wr_conflict = 1 next cycle.
- ZERO_REG=1: address 0 reads 0; writes to it are discarded and never raise wr_conflict; sb_set on 0 is ignored. ZERO_REG=0: register 0 is ordinary.
- Read, BYPASS=1: if the read address matches an enabled write this cycle, return that write's data (wr1 over wr0); else the stored value. Zero-register rule overrides.
- Read, BYPASS=0: stored value only.
- Scoreboard, per register at the edge:
  - set if sb_set_en targets it;
  - otherwise cleared if either write port targets it;
  - otherwise held.
  - Set wins over a same-cycle write to the same address; the data is still written.
- rd_busy_x = stored busy bit. With BYPASS=1, it is forced 0 when a write to that address occurs this cycle and no sb_set targets it.
- sb_count is the population count of the busy vector after the edge's update, registered. It changes one cycle after the causing event and never exceeds DEPTH (or DEPTH−1 with ZERO_REG=1).

## Timing
- Read latency is 0 cycles (combinational). Write-to-read latency is 0 cycles with BYPASS=1 and 1 cycle with BYPASS=0.
- Reset (rst=1 at an edge): all registers 0, all busy bits 0, sb_count 0, wr_conflict 0.
- Reset dominates all same-cycle writes and sets.
- Reset mid-operation discards pending busy state; no clear is required afterwards.
- wr_conflict is high for exactly the one cycle following the conflicting edge. Back-to-back conflicts hold it high.
- No back-pressure. Writes to a busy register are always accepted. The scoreboard is advisory; stall decisions belong to hazard control.

## Test plan
- Reset, then read all addresses → every rd_data = 0, rd_busy = 0, sb_count = 0, spec_data = 0.
- wr0 to r3 = 0x7B18 with rd_addr_a = 3 in the same cycle → with BYPASS=1, rd_data_a = 0x7B18 that cycle; with BYPASS=0, old value that cycle and 0x7B18 the next.
- Same edge: wr0 r5 = 0x1111 and wr1 r5 = 0x2222 → r5 = 0x2222; wr_conflict = 1 for one cycle. Repeat with r0 → r0 stays 0, no conflict.
- sb_set r7, then r9, then wr1 r7 = 0x00FF → sb_count goes 1, 2, 1; rd_busy on r7 is 0 after the write, r9 stays 1.
- Same edge: sb_set r4 and wr0 r4 = 0xF0FF → r4 = 0xF0FF, busy bit r4 = 1, sb_count +1.
- Set busy on r2 and r15 and write r15 = 0x0011 (spec_data = 0x0011 with SPEC_IDX=15), then assert rst for one edge → all registers, busy bits, sb_count and spec_data return to 0.

Source files
------------

// File: rtl/regfile_sb_if.sv
// Decode/execute-side bundle of regfile_sb: two read ports, two write ports,
// scoreboard set request and the status outputs.
interface regfile_sb_if #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 4
);
    logic [ADDR_W-1:0] rd_addr_a;
    logic [ADDR_W-1:0] rd_addr_b;
    logic [WIDTH-1:0]  rd_data_a;
    logic [WIDTH-1:0]  rd_data_b;
    logic              rd_busy_a;
    logic              rd_busy_b;
    logic [WIDTH-1:0]  spec_data;

    logic              wr0_en;
    logic [ADDR_W-1:0] wr0_addr;
    logic [WIDTH-1:0]  wr0_data;
    logic              wr1_en;
    logic [ADDR_W-1:0] wr1_addr;
    logic [WIDTH-1:0]  wr1_data;

    logic              sb_set_en;
    logic [ADDR_W-1:0] sb_set_addr;
    logic [ADDR_W:0]   sb_count;
    logic              wr_conflict;

    modport master (
        output rd_addr_a, rd_addr_b,
        output wr0_en, wr0_addr, wr0_data,
        output wr1_en, wr1_addr, wr1_data,
        output sb_set_en, sb_set_addr,
        input  rd_data_a, rd_data_b, rd_busy_a, rd_busy_b, spec_data,
        input  sb_count, wr_conflict
    );

    modport slave (
        input  rd_addr_a, rd_addr_b,
        input  wr0_en, wr0_addr, wr0_data,
        input  wr1_en, wr1_addr, wr1_data,
        input  sb_set_en, sb_set_addr,
        output rd_data_a, rd_data_b, rd_busy_a, rd_busy_b, spec_data,
        output sb_count, wr_conflict
    );
endinterface

// File: rtl/regfile_sb.sv
// Two-write-port register file with optional write bypass, hardwired zero
// register and a per-register busy scoreboard for multi-cycle results.
module regfile_sb #(
    parameter int WIDTH    = 16,
    parameter int ADDR_W   = 4,
    parameter int SPEC_IDX = 15,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic         clk,
    input  logic         rst,
    regfile_sb_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] SPEC_ADDR = ADDR_W'(SPEC_IDX);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [DEPTH-1:0] busy_q, busy_d;
    logic [ADDR_W:0]  sb_count_q, sb_count_d;
    logic             wr_conflict_q, wr_conflict_d;
    logic             wr0_ok, wr1_ok, set_ok;

    function automatic logic is_zero(input logic [ADDR_W-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    assign wr0_ok = bus.wr0_en    && !is_zero(bus.wr0_addr);
    assign wr1_ok = bus.wr1_en    && !is_zero(bus.wr1_addr);
    assign set_ok = bus.sb_set_en && !is_zero(bus.sb_set_addr);

    // NOTE: every always_comb output gets its default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        mem_d  = mem_q;
        busy_d = busy_q;
        // wr1 is applied last so it overwrites wr0 on an address clash.
        if (wr0_ok) begin
            mem_d[bus.wr0_addr]  = bus.wr0_data;
            busy_d[bus.wr0_addr] = 1'b0;
        end
        if (wr1_ok) begin
            mem_d[bus.wr1_addr]  = bus.wr1_data;
            busy_d[bus.wr1_addr] = 1'b0;
        end
        if (set_ok) begin
            busy_d[bus.sb_set_addr] = 1'b1;
        end
        wr_conflict_d = wr0_ok && wr1_ok && (bus.wr0_addr == bus.wr1_addr);
        sb_count_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            sb_count_d = sb_count_d + (ADDR_W+1)'(busy_d[i]);
        end
    end

    // NOTE: state uses non-blocking assignments; the storage array is reset
    // too because the architecture requires every register to read 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            busy_q        <= '0;
            sb_count_q    <= '0;
            wr_conflict_q <= 1'b0;
        end else begin
            mem_q         <= mem_d;
            busy_q        <= busy_d;
            sb_count_q    <= sb_count_d;
            wr_conflict_q <= wr_conflict_d;
        end
    end

    function automatic logic [WIDTH-1:0] read_data(input logic [ADDR_W-1:0] a);
        if (is_zero(a)) begin
            return '0;
        end
        if (BYPASS != 0 && wr1_ok && bus.wr1_addr == a) begin
            return bus.wr1_data;
        end
        if (BYPASS != 0 && wr0_ok && bus.wr0_addr == a) begin
            return bus.wr0_data;
        end
        return mem_q[a];
    endfunction

    function automatic logic read_busy(input logic [ADDR_W-1:0] a);
        logic hit;
        hit = (wr0_ok && bus.wr0_addr == a) || (wr1_ok && bus.wr1_addr == a);
        // A completing write hides the busy bit unless a new issue re-claims it.
        if (BYPASS != 0 && hit && !(set_ok && bus.sb_set_addr == a)) begin
            return 1'b0;
        end
        return busy_q[a];
    endfunction

    assign bus.rd_data_a   = read_data(bus.rd_addr_a);
    assign bus.rd_data_b   = read_data(bus.rd_addr_b);
    assign bus.rd_busy_a   = read_busy(bus.rd_addr_a);
    assign bus.rd_busy_b   = read_busy(bus.rd_addr_b);
    assign bus.spec_data   = read_data(SPEC_ADDR);
    assign bus.sb_count    = sb_count_q;
    assign bus.wr_conflict = wr_conflict_q;
endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: directed vector table on the default build plus a
// randomized run of a bypass/zero build and a no-bypass/no-zero build.
module tb_regfile_sb;
    localparam int W  = 16;
    localparam int AW = 4;
    localparam int D  = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;

    regfile_sb_if #(.WIDTH(W), .ADDR_W(AW)) bus ();
    regfile_sb_if #(.WIDTH(W), .ADDR_W(AW)) bus_nb ();

    assign bus_nb.rd_addr_a   = bus.rd_addr_a;
    assign bus_nb.rd_addr_b   = bus.rd_addr_b;
    assign bus_nb.wr0_en      = bus.wr0_en;
    assign bus_nb.wr0_addr    = bus.wr0_addr;
    assign bus_nb.wr0_data    = bus.wr0_data;
    assign bus_nb.wr1_en      = bus.wr1_en;
    assign bus_nb.wr1_addr    = bus.wr1_addr;
    assign bus_nb.wr1_data    = bus.wr1_data;
    assign bus_nb.sb_set_en   = bus.sb_set_en;
    assign bus_nb.sb_set_addr = bus.sb_set_addr;

    regfile_sb #(.WIDTH(W), .ADDR_W(AW), .SPEC_IDX(15), .BYPASS(1), .ZERO_REG(1))
        u_dut (.clk(clk), .rst(rst), .bus(bus.slave));
    regfile_sb #(.WIDTH(W), .ADDR_W(AW), .SPEC_IDX(15), .BYPASS(0), .ZERO_REG(0))
        u_dut_nb (.clk(clk), .rst(rst), .bus(bus_nb.slave));

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        w0e;
        logic [3:0]  w0a;
        logic [15:0] w0d;
        logic        w1e;
        logic [3:0]  w1a;
        logic [15:0] w1d;
        logic        se;
        logic [3:0]  sa;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [15:0] exp_a;
        logic        exp_ba;
        logic [15:0] exp_b;
        logic        exp_bb;
        logic [15:0] exp_spec;
        logic [4:0]  exp_cnt;
        logic        exp_conf;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: config 0 = bypass + zero register, config 1 = neither.
    logic [15:0] m_regs [2][D];
    logic [15:0] m_busy [2];
    int          m_cnt  [2];
    logic        m_conf [2];
    bit          cfg_bypass [2] = '{1'b1, 1'b0};
    bit          cfg_zero   [2] = '{1'b1, 1'b0};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic bit m_zero(input int c, input logic [3:0] a);
        return cfg_zero[c] && a == 4'd0;
    endfunction

    function automatic logic [15:0] m_read(input int c, input logic [3:0] a);
        if (m_zero(c, a)) return 16'h0;
        if (cfg_bypass[c] && bus.wr1_en && bus.wr1_addr == a) return bus.wr1_data;
        if (cfg_bypass[c] && bus.wr0_en && bus.wr0_addr == a) return bus.wr0_data;
        return m_regs[c][a];
    endfunction

    function automatic logic m_rbusy(input int c, input logic [3:0] a);
        bit written, issued;
        if (m_zero(c, a)) return 1'b0;
        written = (bus.wr0_en && bus.wr0_addr == a) || (bus.wr1_en && bus.wr1_addr == a);
        issued  = bus.sb_set_en && bus.sb_set_addr == a;
        if (cfg_bypass[c] && written && !issued) return 1'b0;
        return m_busy[c][a];
    endfunction

    task automatic model_edge();
        for (int c = 0; c < 2; c++) begin
            if (rst) begin
                for (int r = 0; r < D; r++) m_regs[c][r] = 16'h0;
                m_busy[c] = 16'h0;
                m_cnt[c]  = 0;
                m_conf[c] = 1'b0;
            end else begin
                logic [15:0] nb;
                bit w0v, w1v;
                w0v = bus.wr0_en && !m_zero(c, bus.wr0_addr);
                w1v = bus.wr1_en && !m_zero(c, bus.wr1_addr);
                m_conf[c] = w0v && w1v && bus.wr0_addr == bus.wr1_addr;
                for (int r = 0; r < D; r++) begin
                    bit set_hit, wr_hit;
                    set_hit = bus.sb_set_en && bus.sb_set_addr == 4'(r) && !m_zero(c, 4'(r));
                    wr_hit  = (w0v && bus.wr0_addr == 4'(r)) || (w1v && bus.wr1_addr == 4'(r));
                    nb[r] = set_hit ? 1'b1 : (wr_hit ? 1'b0 : m_busy[c][r]);
                end
                if (w0v && !(w1v && bus.wr1_addr == bus.wr0_addr)) m_regs[c][bus.wr0_addr] = bus.wr0_data;
                if (w1v) m_regs[c][bus.wr1_addr] = bus.wr1_data;
                m_busy[c] = nb;
                m_cnt[c]  = $countones(nb);
            end
        end
    endtask

    task automatic drive(input vec_t v);
        rst             = v.rst;
        bus.wr0_en      = v.w0e;
        bus.wr0_addr    = v.w0a;
        bus.wr0_data    = v.w0d;
        bus.wr1_en      = v.w1e;
        bus.wr1_addr    = v.w1a;
        bus.wr1_data    = v.w1d;
        bus.sb_set_en   = v.se;
        bus.sb_set_addr = v.sa;
        bus.rd_addr_a   = v.ra;
        bus.rd_addr_b   = v.rb;
    endtask

    task automatic check_model(input string tag);
        check({tag, " a0"},    32'(bus.rd_data_a),   32'(m_read(0, bus.rd_addr_a)));
        check({tag, " b0"},    32'(bus.rd_data_b),   32'(m_read(0, bus.rd_addr_b)));
        check({tag, " ba0"},   32'(bus.rd_busy_a),   32'(m_rbusy(0, bus.rd_addr_a)));
        check({tag, " bb0"},   32'(bus.rd_busy_b),   32'(m_rbusy(0, bus.rd_addr_b)));
        check({tag, " spec0"}, 32'(bus.spec_data),   32'(m_read(0, 4'd15)));
        check({tag, " cnt0"},  32'(bus.sb_count),    32'(m_cnt[0]));
        check({tag, " conf0"}, 32'(bus.wr_conflict), 32'(m_conf[0]));
        check({tag, " a1"},    32'(bus_nb.rd_data_a),   32'(m_read(1, bus.rd_addr_a)));
        check({tag, " b1"},    32'(bus_nb.rd_data_b),   32'(m_read(1, bus.rd_addr_b)));
        check({tag, " ba1"},   32'(bus_nb.rd_busy_a),   32'(m_rbusy(1, bus.rd_addr_a)));
        check({tag, " bb1"},   32'(bus_nb.rd_busy_b),   32'(m_rbusy(1, bus.rd_addr_b)));
        check({tag, " spec1"}, 32'(bus_nb.spec_data),   32'(m_read(1, 4'd15)));
        check({tag, " cnt1"},  32'(bus_nb.sb_count),    32'(m_cnt[1]));
        check({tag, " conf1"}, 32'(bus_nb.wr_conflict), 32'(m_conf[1]));
    endtask

    vec_t vecs[$];

    initial begin
        vec_t v;
        for (int c = 0; c < 2; c++) begin
            for (int r = 0; r < D; r++) m_regs[c][r] = 16'h0;
            m_busy[c] = 16'h0;
            m_cnt[c]  = 0;
            m_conf[c] = 1'b0;
        end

        // rst w0e w0a w0d w1e w1a w1d se sa ra rb | a ba b bb spec cnt conf
        vecs.push_back(vec_t'{0,0,0,16'h0,   0,0,16'h0,   0,0,  3,15, 16'h0,0,16'h0,0,16'h0,0,0});
        vecs.push_back(vec_t'{0,1,3,16'h7B18,0,0,16'h0,   0,0,  3,3,  16'h7B18,0,16'h7B18,0,16'h0,0,0});
        vecs.push_back(vec_t'{0,0,0,16'h0,   0,0,16'h0,   0,0,  3,5,  16'h7B18,0,16'h0,0,16'h0,0,0});
        vecs.push_back(vec_t'{0,1,5,16'h1111,1,5,16'h2222,0,0,  5,3,  16'h2222,0,16'h7B18,0,16'h0,0,0});
        vecs.push_back(vec_t'{0,0,0,16'h0,   0,0,16'h0,   0,0,  5,0,  16'h2222,0,16'h0,0,16'h0,0,1});
        vecs.push_back(vec_t'{0,1,0,16'hAAAA,1,0,16'hBBBB,0,0,  0,5,  16'h0,0,16'h2222,0,16'h0,0,0});
        vecs.push_back(vec_t'{0,1,6,16'h0001,1,6,16'h0002,0,0,  6,0,  16'h0002,0,16'h0,0,16'h0,0,0});
        vecs.push_back(vec_t'{0,1,6,16'h0003,1,6,16'h0004,0,0,  6,5,  16'h0004,0,16'h2222,0,16'h0,0,1});
        vecs.push_back(vec_t'{0,0,0,16'h0,   0,0,16'h0,   0,0,  6,0,  16'h0004,0,16'h0,0,16'h0,0,1});
        vecs.push_back(vec_t'{0,0,0,16'h0,   0,0,16'h0,   0,0,  6,0,  16'h0004,0,16'h0,0,16'h0,0,0});
        vecs.push_back(vec_t'{0,0,0,16'h0,   0,0,16'h0,   1,7,  7,9,  16'h0,0,16'h0,0,16'h0,0,0});
        vecs.push_back(vec_t'{0,0,0,16'h0,   0,0,16'h0,   1,9,  7,9,  16'h0,1,16'h0,0,16'h0,1,0});
        vecs.push_back(vec_t'{0,0,0,16'h0,   1,7,16'h00FF,0,0,  7,9,  16'h00FF,0,16'h0,1,16'h0,2,0});
        vecs.push_back(vec_t'{0,0,0,16'h0,   0,0,16'h0,   0,0,  7,9,  16'h00FF,0,16'h0,1,16'h0,1,0});
        vecs.push_back(vec_t'{0,1,4,16'hF0FF,0,0,16'h0,   1,4,  4,9,  16'hF0FF,0,16'h0,1,16'h0,1,0});
        vecs.push_back(vec_t'{0,0,0,16'h0,   0,0,16'h0,   0,0,  4,9,  16'hF0FF,1,16'h0,1,16'h0,2,0});
        vecs.push_back(vec_t'{0,0,0,16'h0,   0,0,16'h0,   1,2,  2,4,  16'h0,0,16'hF0FF,1,16'h0,2,0});
        vecs.push_back(vec_t'{0,0,0,16'h0,   1,15,16'h0011,1,15,15,2, 16'h0011,0,16'h0,1,16'h0011,3,0});
        vecs.push_back(vec_t'{0,0,0,16'h0,   0,0,16'h0,   0,0,  15,2, 16'h0011,1,16'h0,1,16'h0011,4,0});
        vecs.push_back(vec_t'{1,1,3,16'hFFFF,0,0,16'h0,   1,6,  15,9, 16'h0011,1,16'h0,1,16'h0011,4,0});
        vecs.push_back(vec_t'{0,0,0,16'h0,   0,0,16'h0,   0,0,  15,3, 16'h0,0,16'h0,0,16'h0,0,0});
        vecs.push_back(vec_t'{0,0,0,16'h0,   0,0,16'h0,   0,0,  6,4,  16'h0,0,16'h0,0,16'h0,0,0});

        // Reset with every input quiet, then sweep all addresses combinationally.
        v = vec_t'{1,0,0,16'h0,0,0,16'h0,0,0,0,0,16'h0,0,16'h0,0,16'h0,0,0};
        drive(v);
        repeat (2) begin
            @(posedge clk);
            model_edge();
        end
        @(negedge clk);
        rst = 1'b0;
        for (int a = 0; a < D; a++) begin
            bus.rd_addr_a = 4'(a);
            bus.rd_addr_b = 4'(D - 1 - a);
            #1;
            check($sformatf("reset a r%0d", a), 32'(bus.rd_data_a), 32'h0);
            check($sformatf("reset busy r%0d", a), 32'(bus.rd_busy_a), 32'h0);
            check($sformatf("reset nb b r%0d", a), 32'(bus_nb.rd_data_b), 32'h0);
        end
        check("reset cnt", 32'(bus.sb_count), 32'h0);
        check("reset spec", 32'(bus.spec_data), 32'h0);

        // Directed table: default build against constants, other build against model.
        for (int i = 0; i < vecs.size(); i++) begin
            string tag;
            @(negedge clk);
            drive(vecs[i]);
            #1;
            tag = $sformatf("vec%0d", i);
            check({tag, " rd_a"},  32'(bus.rd_data_a),   32'(vecs[i].exp_a));
            check({tag, " busy_a"},32'(bus.rd_busy_a),   32'(vecs[i].exp_ba));
            check({tag, " rd_b"},  32'(bus.rd_data_b),   32'(vecs[i].exp_b));
            check({tag, " busy_b"},32'(bus.rd_busy_b),   32'(vecs[i].exp_bb));
            check({tag, " spec"},  32'(bus.spec_data),   32'(vecs[i].exp_spec));
            check({tag, " cnt"},   32'(bus.sb_count),    32'(vecs[i].exp_cnt));
            check({tag, " conf"},  32'(bus.wr_conflict), 32'(vecs[i].exp_conf));
            check_model(tag);
            @(posedge clk);
            model_edge();
        end

        // Non-bypass write-to-read latency: old value this cycle, new one next.
        @(negedge clk);
        v = vec_t'{0,1,3,16'h7B18,0,0,16'h0,0,0,3,3,16'h0,0,16'h0,0,16'h0,0,0};
        drive(v);
        #1;
        check("nb w2r same cycle", 32'(bus_nb.rd_data_a), 32'h0);
        check("byp w2r same cycle", 32'(bus.rd_data_a), 32'h7B18);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        bus.wr0_en = 1'b0;
        #1;
        check("nb w2r next cycle", 32'(bus_nb.rd_data_a), 32'h7B18);

        // Randomized run; narrow write/set address range to provoke collisions.
        for (int i = 0; i < 600; i++) begin
            v.rst = ($urandom_range(0, 49) == 0);
            v.w0e = $urandom_range(0, 1) == 1;
            v.w0a = 4'($urandom_range(0, 7));
            v.w0d = 16'($urandom);
            v.w1e = $urandom_range(0, 2) == 0;
            v.w1a = 4'($urandom_range(0, 7));
            v.w1d = 16'($urandom);
            v.se  = $urandom_range(0, 2) == 0;
            v.sa  = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom_range(0, 7));
            v.ra  = ($urandom_range(0, 1) == 0) ? v.w0a : 4'($urandom_range(0, 15));
            v.rb  = ($urandom_range(0, 1) == 0) ? v.w1a : 4'($urandom_range(0, 15));
            @(negedge clk);
            drive(v);
            #1;
            check_model($sformatf("rnd%0d", i));
            @(posedge clk);
            model_edge();
        end

        @(negedge clk);
        #1;
        check_model("final");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
